pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, range 1..7: bubble cycles before entering HALTED.
REQ-002 SHALL have i_clk  in  1  clock; all state updates occur on its rising edge.
REQ-003 SHALL have i_reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have i_start  in  1  debug-unit run command (level, sampled in IDLE).
REQ-005 SHALL have i_step  in  1  debug-unit single-step command (sampled in IDLE).
REQ-006 SHALL have i_halt_instr  in  1  halt instruction decoded in ID.
REQ-007 SHALL have i_jump_taken  in  1  jump/branch resolved taken in ID.
REQ-008 SHALL have i_id_rs, i_id_rt  in  5 each  source registers in ID.
REQ-009 SHALL have i_id_uses_rt  in  1  ID instruction reads rt.
REQ-010 SHALL have i_ex_rt  in  5  destination register of the load in EX.
REQ-011 SHALL have i_ex_mem_to_reg  in  1  instruction in EX is a load.
REQ-012 SHALL have o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage enables.
REQ-013 SHALL have o_if_id_flush, o_id_ex_flush  out  1 each  bubble injection.
REQ-014 SHALL have o_state  out  3  current state; o_halted  out  1; o_step_done  out  1.

Function
REQ-015 States SHALL be IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; other codes SHALL go to IDLE.
REQ-016 Load-use hazard SHALL be i_ex_mem_to_reg and i_ex_rt!=0 and (i_ex_rt==i_id_rs or (i_id_uses_rt and i_ex_rt==i_id_rt)).
REQ-017 IDLE: all enables and flushes 0; i_start -> RUN; else i_step -> STEP; i_start wins if both are high.
REQ-018 RUN/STEP: all enables 1, flushes 0, except as modified by REQ-019 and REQ-020.
REQ-019 On hazard (RUN/STEP): o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, in the same cycle (combinational).
REQ-020 On i_jump_taken without hazard: o_if_id_flush=1; with hazard, the hazard wins and the flush is suppressed.
REQ-021 i_halt_instr without hazard in RUN/STEP SHALL go to DRAIN and load the counter with DRAIN_CYCLES.
REQ-022 STEP SHALL last exactly one cycle, then go to IDLE unless REQ-021 applies; o_step_done SHALL be a registered one-cycle pulse in the following cycle.
REQ-023 A hazard in STEP SHALL stay in STEP for another cycle (the step completes only when ID advances).
REQ-024 DRAIN: o_pc_en=0, o_if_id_en=0, o_id_ex_en=1, o_id_ex_flush=1, o_ex_mem_en=1, o_mem_wb_en=1.
REQ-025 DRAIN: the counter SHALL decrement each cycle; at 1 the next state SHALL be HALTED.
REQ-026 DRAIN: i_jump_taken, hazard, i_start and i_step SHALL be ignored.
REQ-027 HALTED: all enables 0, o_halted=1; SHALL hold until reset.
REQ-028 o_state SHALL mirror the state register.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, o_step_done 0, all enables/flushes 0, o_halted 0, regardless of clock.
REQ-030 Reset asserted mid-DRAIN or mid-STEP SHALL abandon the operation with no pulse on o_step_done.

Configuration
REQ-031 With PIPELINE_CTRL_STEP_EN defined, STEP and o_step_done SHALL operate as specified.
REQ-032 Without PIPELINE_CTRL_STEP_EN, i_step SHALL be ignored, STEP SHALL be unreachable (code treated per REQ-015), and o_step_done SHALL be constant 0.

Structure
REQ-033 Shared header pipeline_ctrl.vh SHALL hold the state encodings and DEFAULT_DRAIN_CYCLES.
REQ-034 Hazard compare SHALL be a combinational sub-module hazard_detect.

Verification
REQ-035 Reset, then i_start=1 -> RUN next cycle, all five enables 1, both flushes 0.
REQ-036 RUN, i_ex_mem_to_reg=1, i_ex_rt=5, i_id_rs=5, i_jump_taken=1 -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_if_id_flush=0; repeat with i_ex_rt=0 -> no stall, o_if_id_flush=1.
REQ-037 RUN, i_halt_instr=1, DRAIN_CYCLES=4 -> 4 DRAIN cycles with o_id_ex_flush=1, then o_halted=1; i_start afterwards has no effect.
REQ-038 IDLE, i_step pulse -> exactly one cycle with enables 1, then IDLE with o_step_done=1 for one cycle; same with hazard present -> two STEP cycles.
REQ-039 Assert i_reset during the 2nd DRAIN cycle -> o_state=0 immediately, all outputs 0.
REQ-040 Build without PIPELINE_CTRL_STEP_EN, i_step=1 in IDLE -> stays IDLE, o_step_done=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encodings, the
// default drain length, field widths and a helper that sanitises the drain
// length loaded into the counter.
package pipeline_ctrl_pkg;

  localparam int REG_W                = 5;
  localparam int CNT_W                = 3;
  localparam int DEFAULT_DRAIN_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Drain length is meaningful in 1..7; clamp so a bad override can never
  // load 0 (which would skip straight past the countdown).
  function automatic logic [CNT_W-1:0] drain_load(input int n);
    if (n < 1) begin
      return CNT_W'(1);
    end else if (n > 7) begin
      return CNT_W'(7);
    end else begin
      return CNT_W'(n);
    end
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// (non-zero) is read by the instruction in ID. Purely combinational.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             i_ex_mem_to_reg,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (i_ex_rt == i_id_rs);
  assign rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign o_hazard = i_ex_mem_to_reg && (i_ex_rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: sequences a 5-stage pipeline through
// IDLE -> RUN/STEP -> DRAIN -> HALTED, stalls on load-use hazards and
// flushes IF/ID on taken jumps.
// Optional feature: define PIPELINE_CTRL_STEP_EN to enable debug single-step
// (STEP state and o_step_done). Without it, i_step is ignored and
// o_step_done is tied low.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_halt_instr,
  input  logic             i_jump_taken,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_mem_to_reg,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_step_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             active;

`ifdef PIPELINE_CTRL_STEP_EN
  logic             step_done_q, step_done_d;
`else
  logic             unused_step;
  assign unused_step = i_step;
`endif

  hazard_detect u_hazard_detect (
    .i_ex_mem_to_reg (i_ex_mem_to_reg),
    .i_ex_rt         (i_ex_rt),
    .i_id_rs         (i_id_rs),
    .i_id_rt         (i_id_rt),
    .i_id_uses_rt    (i_id_uses_rt),
    .o_hazard        (hazard)
  );

  // State, drain counter and step-done pulse registers; reset is asynchronous.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
`ifdef PIPELINE_CTRL_STEP_EN
      step_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef PIPELINE_CTRL_STEP_EN
      step_done_q <= step_done_d;
`endif
    end
  end

  // Next-state, counter and stage-control decode from the current state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active        = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;
`ifdef PIPELINE_CTRL_STEP_EN
    step_done_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Run takes priority over single-step when both are requested.
        if (i_start) begin
          state_d = ST_RUN;
        end
`ifdef PIPELINE_CTRL_STEP_EN
        else if (i_step) begin
          state_d = ST_STEP;
        end
`endif
      end

      ST_RUN: begin
        active = 1'b1;
        // A stalled halt has not really issued yet; wait until ID advances.
        if (i_halt_instr && !hazard) begin
          state_d = ST_DRAIN;
          cnt_d   = drain_load(DRAIN_CYCLES);
        end
      end

`ifdef PIPELINE_CTRL_STEP_EN
      ST_STEP: begin
        active = 1'b1;
        // The step only completes once the ID instruction actually moves on.
        if (!hazard) begin
          step_done_d = 1'b1;
          if (i_halt_instr) begin
            state_d = ST_DRAIN;
            cnt_d   = drain_load(DRAIN_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif

      ST_DRAIN: begin
        // Front end frozen, bubbles fed into EX while the back end empties.
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        o_halted = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared RUN/STEP stage control: hazard stall beats jump flush.
    if (active) begin
      o_pc_en     = !hazard;
      o_if_id_en  = !hazard;
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
      o_mem_wb_en = 1'b1;
      o_id_ex_flush = hazard;
      o_if_id_flush = i_jump_taken && !hazard;
    end
  end

  assign o_state = state_q;

`ifdef PIPELINE_CTRL_STEP_EN
  assign o_step_done = step_done_q;
`else
  assign o_step_done = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table walks IDLE -> RUN ->
// DRAIN -> HALTED, followed by hand-written reset and step sequences.
module tb_pipeline_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_step = 1'b0;
  logic       i_halt_instr = 1'b0;
  logic       i_jump_taken = 1'b0;
  logic [4:0] i_id_rs = '0;
  logic [4:0] i_id_rt = '0;
  logic       i_id_uses_rt = 1'b0;
  logic [4:0] i_ex_rt = '0;
  logic       i_ex_mem_to_reg = 1'b0;
  logic       o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic       o_if_id_flush, o_id_ex_flush;
  logic [2:0] o_state;
  logic       o_halted, o_step_done;

  int checks = 0;
  int failures = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(4)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_step          (i_step),
    .i_halt_instr    (i_halt_instr),
    .i_jump_taken    (i_jump_taken),
    .i_id_rs         (i_id_rs),
    .i_id_rt         (i_id_rt),
    .i_id_uses_rt    (i_id_uses_rt),
    .i_ex_rt         (i_ex_rt),
    .i_ex_mem_to_reg (i_ex_mem_to_reg),
    .o_pc_en         (o_pc_en),
    .o_if_id_en      (o_if_id_en),
    .o_id_ex_en      (o_id_ex_en),
    .o_ex_mem_en     (o_ex_mem_en),
    .o_mem_wb_en     (o_mem_wb_en),
    .o_if_id_flush   (o_if_id_flush),
    .o_id_ex_flush   (o_id_ex_flush),
    .o_state         (o_state),
    .o_halted        (o_halted),
    .o_step_done     (o_step_done)
  );

  always #5 i_clk = ~i_clk;

  // Output bundle: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, state, halted, step_done}
  localparam logic [11:0] E_IDLE       = 12'b00000_00_000_0_0;
  localparam logic [11:0] E_RUN        = 12'b11111_00_001_0_0;
  localparam logic [11:0] E_RUN_STALL  = 12'b00111_01_001_0_0;
  localparam logic [11:0] E_RUN_JF     = 12'b11111_10_001_0_0;
  localparam logic [11:0] E_DRAIN      = 12'b00111_01_011_0_0;
  localparam logic [11:0] E_HALT       = 12'b00000_00_100_1_0;
`ifdef PIPELINE_CTRL_STEP_EN
  localparam logic [11:0] E_STEP       = 12'b11111_00_010_0_0;
  localparam logic [11:0] E_STEP_STALL = 12'b00111_01_010_0_0;
  localparam logic [11:0] E_STEP_DONE  = 12'b00000_00_000_0_1;
`endif

  typedef struct {
    logic       start;
    logic       step;
    logic       halt;
    logic       jump;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] ex_rt;
    logic       m2r;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic start, input logic step, input logic halt,
                              input logic jump, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic [4:0] ex_rt, input logic m2r,
                              input logic [11:0] exp);
    vec_t v;
    v.start = start; v.step = step; v.halt = halt; v.jump = jump;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_rt = ex_rt; v.m2r = m2r;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
            o_if_id_flush, o_id_ex_flush, o_state, o_halted, o_step_done};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    i_start = v.start; i_step = v.step; i_halt_instr = v.halt; i_jump_taken = v.jump;
    i_id_rs = v.rs; i_id_rt = v.rt; i_id_uses_rt = v.uses_rt;
    i_ex_rt = v.ex_rt; i_ex_mem_to_reg = v.m2r;
  endtask

  // Apply inputs after the falling edge, check outputs for the current state.
  task automatic drive(input vec_t v, input string name);
    @(negedge i_clk);
    set_in(v);
    #1;
    check(name, outs(), v.exp);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    set_in(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE));
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  nd;
    bit  done;
    bit  flush_bad;

    //            start step halt jump rs     rt     uses ex_rt  m2r  expected
    tbl[0]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_IDLE);
    tbl[1]  = mk(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_IDLE);
    tbl[2]  = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_RUN);
    tbl[3]  = mk(0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, E_RUN_STALL);
    tbl[4]  = mk(0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd0, 1, E_RUN_JF);
    tbl[5]  = mk(0, 0, 0, 0, 5'd3, 5'd7, 1, 5'd7, 1, E_RUN_STALL);
    tbl[6]  = mk(0, 0, 0, 0, 5'd3, 5'd7, 0, 5'd7, 1, E_RUN);
    tbl[7]  = mk(0, 0, 0, 0, 5'd9, 5'd0, 0, 5'd9, 0, E_RUN);
    tbl[8]  = mk(0, 0, 1, 0, 5'd5, 5'd0, 0, 5'd5, 1, E_RUN_STALL);
    tbl[9]  = mk(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_RUN);
    tbl[10] = mk(1, 1, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, E_DRAIN);
    tbl[11] = mk(0, 0, 0, 1, 5'd0, 5'd0, 0, 5'd0, 0, E_DRAIN);
    tbl[12] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_DRAIN);
    tbl[13] = mk(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_DRAIN);
    tbl[14] = mk(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_HALT);
    tbl[15] = mk(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_HALT);
    tbl[16] = mk(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_HALT);

    // Reset state while i_reset is held and no clock edge has been seen yet.
    #1;
    check("reset_state", outs(), E_IDLE);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the second DRAIN cycle.
    do_reset();
    drive(mk(1,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "mid_drain_start");
    drive(mk(0,0,1,0, 5'd0,5'd0,0,5'd0,0, E_RUN),  "mid_drain_halt");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_DRAIN), "mid_drain_d1");
    @(negedge i_clk);
    #1;
    check("mid_drain_d2", outs(), E_DRAIN);
    #1;
    i_reset = 1'b1;
    #1;
    check("mid_drain_async_reset", outs(), E_IDLE);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check("mid_drain_after_reset", outs(), E_IDLE);

    // Full drain after the abandoned one: count DRAIN cycles up to HALTED.
    drive(mk(1,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "count_start");
    drive(mk(0,0,1,0, 5'd0,5'd0,0,5'd0,0, E_RUN),  "count_halt");
    nd = 0;
    done = 1'b0;
    flush_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      set_in(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE));
      #1;
      if (o_halted) begin
        done = 1'b1;
        break;
      end
      if (o_state == 3'd3) begin
        nd++;
        if (!o_id_ex_flush) flush_bad = 1'b1;
      end
    end
    check_int("drain_reached_halted", int'(done), 1);
    check_int("drain_cycle_count", nd, 4);
    check_int("drain_flush_every_cycle", int'(flush_bad), 0);

`ifdef PIPELINE_CTRL_STEP_EN
    do_reset();
    drive(mk(0,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_req");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_STEP),      "step_active");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_STEP_DONE), "step_done_pulse");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_done_clear");
    drive(mk(0,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_haz_req");
    drive(mk(0,0,0,0, 5'd5,5'd0,0,5'd5,1, E_STEP_STALL),"step_haz_stall");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_STEP),      "step_haz_second");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_STEP_DONE), "step_haz_done");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_haz_clear");
    drive(mk(0,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_rst_req");
    @(negedge i_clk);
    set_in(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE));
    #1;
    check("step_rst_in_step", outs(), E_STEP);
    #1;
    i_reset = 1'b1;
    #1;
    check("step_rst_async", outs(), E_IDLE);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check("step_rst_no_pulse", outs(), E_IDLE);
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE),      "step_rst_no_pulse2");
`else
    do_reset();
    drive(mk(0,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "nostep_req");
    drive(mk(0,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "nostep_held");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "nostep_after");
    drive(mk(1,1,0,0, 5'd0,5'd0,0,5'd0,0, E_IDLE), "nostep_start");
    drive(mk(0,0,0,0, 5'd0,5'd0,0,5'd0,0, E_RUN),  "nostep_run");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
